// File: rtl/regfile_mp_if.sv
// Bus bundle for regfile_mp: write, mark, read, clear and debug signals.
// No valid/ready handshake here: wen/mark_en/clr_req are sampled every rising edge, reads are combinational.
interface regfile_mp_if #(
  parameter int DATA_W = 32,
  parameter int NREG   = 32,
  parameter int NRD    = 2
);
  localparam int NB = DATA_W / 8;
  localparam int AW = $clog2(NREG);

  logic [NB-1:0]         wen;
  logic [AW-1:0]         waddr;
  logic [DATA_W-1:0]     wdata;
  logic [NRD*NB-1:0]     ren;
  logic [NRD*AW-1:0]     raddr;
  logic [NRD*DATA_W-1:0] rdata;
  logic [NRD-1:0]        rpend;
  logic                  mark_en;
  logic [AW-1:0]         mark_addr;
  logic                  clr_req;
  logic                  clr_busy;
  logic [AW-1:0]         test_addr;
  logic [DATA_W-1:0]     test_data;
  logic                  dbg_state;

  modport slave (
    input  wen, waddr, wdata, ren, raddr, mark_en, mark_addr, clr_req, test_addr,
    output rdata, rpend, clr_busy, test_data, dbg_state
  );

  modport master (
    output wen, waddr, wdata, ren, raddr, mark_en, mark_addr, clr_req, test_addr,
    input  rdata, rpend, clr_busy, test_data, dbg_state
  );
endinterface

// File: rtl/regfile_mp.sv
// Multi-port register file with byte enables, pending (scoreboard) bits and a clear sweep.
// Optional macro RF_BYPASS_EN adds same-cycle write-to-read forwarding on the read ports.
module regfile_mp #(
  parameter int DATA_W = 32,
  parameter int NREG   = 32,
  parameter int NRD    = 2
) (
  input  logic          clk,
  input  logic          resetn,
  regfile_mp_if.slave   bus
);
  localparam int NB = DATA_W / 8;
  localparam int AW = $clog2(NREG);

  typedef enum logic {IDLE = 1'b0, SWEEP = 1'b1} state_e;

  state_e                        state_q, state_d;
  logic [AW-1:0]                 idx_q, idx_d;
  logic [NREG-1:0][DATA_W-1:0]   rf_q;
  logic [NREG-1:0]               pend_q;

  logic [NRD*DATA_W-1:0]         rd_all;
  logic [NRD-1:0]                rp_all;
  logic [AW-1:0]                 ra;
  logic [DATA_W-1:0]             word;
  logic                          pnd;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    case (state_q)
      IDLE: if (bus.clr_req) state_d = SWEEP;
      SWEEP: begin
        if (idx_q == AW'(NREG - 1)) begin
          state_d = IDLE;
          idx_d   = AW'(1);
        end else begin
          idx_d = idx_q + AW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Register 0 is never written or marked, so it stays zero from reset onward.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rf_q    <= '0;
      pend_q  <= '0;
      state_q <= IDLE;
      idx_q   <= AW'(1);
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      if (state_q == IDLE) begin
        if (bus.waddr != '0) begin
          for (int k = 0; k < NB; k++)
            if (bus.wen[k]) rf_q[bus.waddr][k*8 +: 8] <= bus.wdata[k*8 +: 8];
          if (|bus.wen) pend_q[bus.waddr] <= 1'b0;
        end
        // Placed after the write so a same-address mark leaves pending set.
        if (bus.mark_en && bus.mark_addr != '0) pend_q[bus.mark_addr] <= 1'b1;
      end else begin
        rf_q[idx_q]   <= '0;
        pend_q[idx_q] <= 1'b0;
      end
    end
  end

  always_comb begin
    rd_all = '0;
    rp_all = '0;
    ra     = '0;
    word   = '0;
    pnd    = 1'b0;
    for (int i = 0; i < NRD; i++) begin
      ra   = bus.raddr[i*AW +: AW];
      word = (ra == '0) ? '0 : rf_q[ra];
      pnd  = (ra == '0) ? 1'b0 : pend_q[ra];
`ifdef RF_BYPASS_EN
      if (state_q == IDLE && ra == bus.waddr && ra != '0) begin
        for (int k = 0; k < NB; k++)
          if (bus.wen[k]) word[k*8 +: 8] = bus.wdata[k*8 +: 8];
        if (|bus.wen && !(bus.mark_en && bus.mark_addr == ra)) pnd = 1'b0;
      end
`endif
      for (int k = 0; k < NB; k++)
        if (!bus.ren[i*NB + k]) word[k*8 +: 8] = 8'h00;
      rd_all[i*DATA_W +: DATA_W] = word;
      rp_all[i]                  = pnd;
    end
  end

  assign bus.rdata     = rd_all;
  assign bus.rpend     = rp_all;
  assign bus.clr_busy  = (state_q == SWEEP);
  assign bus.dbg_state = state_q;
  assign bus.test_data = (bus.test_addr == '0) ? '0 : rf_q[bus.test_addr];
endmodule

// File: tb/tb_regfile_mp.sv
// Self-checking bench for regfile_mp: directed scenarios plus random traffic against an array model.
module tb_regfile_mp;
  localparam int DATA_W = 32;
  localparam int NREG   = 32;
  localparam int NRD    = 2;
  localparam int NB     = DATA_W / 8;
  localparam int AW     = $clog2(NREG);

  logic clk;
  logic resetn;

  regfile_mp_if #(.DATA_W(DATA_W), .NREG(NREG), .NRD(NRD)) bus ();

  regfile_mp #(.DATA_W(DATA_W), .NREG(NREG), .NRD(NRD)) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus.slave)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // reference model: plain arrays plus a countdown for the sweep
  logic [DATA_W-1:0] m_rf [NREG];
  bit                m_pend [NREG];
  bit                m_sweep;
  int                m_next;

  function automatic void model_reset();
    for (int a = 0; a < NREG; a++) begin
      m_rf[a]   = '0;
      m_pend[a] = 1'b0;
    end
    m_sweep = 1'b0;
    m_next  = 1;
  endfunction

  function automatic void model_edge();
    int wa, ma;
    wa = int'(bus.waddr);
    ma = int'(bus.mark_addr);
    if (!m_sweep) begin
      if (wa != 0) begin
        for (int k = 0; k < NB; k++)
          if (bus.wen[k]) m_rf[wa][k*8 +: 8] = bus.wdata[k*8 +: 8];
        if (bus.wen != '0) m_pend[wa] = 1'b0;
      end
      if (bus.mark_en && ma != 0) m_pend[ma] = 1'b1;
      if (bus.clr_req) begin
        m_sweep = 1'b1;
        m_next  = 1;
      end
    end else begin
      m_rf[m_next]   = '0;
      m_pend[m_next] = 1'b0;
      m_next++;
      if (m_next == NREG) m_sweep = 1'b0;
    end
  endfunction

  function automatic bit bypass_hit(int a);
    bit hit;
    hit = 1'b0;
`ifdef RF_BYPASS_EN
    hit = !m_sweep && a != 0 && a == int'(bus.waddr);
`endif
    return hit;
  endfunction

  function automatic logic [DATA_W-1:0] exp_rd(int i);
    int a;
    logic [DATA_W-1:0] v;
    a = int'(bus.raddr[i*AW +: AW]);
    v = m_rf[a];
    if (bypass_hit(a))
      for (int k = 0; k < NB; k++)
        if (bus.wen[k]) v[k*8 +: 8] = bus.wdata[k*8 +: 8];
    for (int k = 0; k < NB; k++)
      if (!bus.ren[i*NB + k]) v[k*8 +: 8] = 8'h00;
    return v;
  endfunction

  function automatic bit exp_rp(int i);
    int a;
    a = int'(bus.raddr[i*AW +: AW]);
    if (bypass_hit(a) && bus.wen != '0 && !(bus.mark_en && int'(bus.mark_addr) == a))
      return 1'b0;
    return m_pend[a];
  endfunction

  // driver tasks
  task automatic idle_inputs();
    bus.wen       = '0;
    bus.waddr     = '0;
    bus.wdata     = '0;
    bus.ren       = '1;
    bus.raddr     = '0;
    bus.mark_en   = 1'b0;
    bus.mark_addr = '0;
    bus.clr_req   = 1'b0;
    bus.test_addr = '0;
  endtask

  // Called at posedge+1: compare outputs to the model, then advance one edge.
  task automatic step();
    #2;
    for (int i = 0; i < NRD; i++) begin
      check_eq("rdata", bus.rdata[i*DATA_W +: DATA_W], exp_rd(i));
      check_eq("rpend", bus.rpend[i], exp_rp(i));
    end
    check_eq("clr_busy", bus.clr_busy, m_sweep);
    check_eq("test_data", bus.test_data, m_rf[int'(bus.test_addr)]);
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic write_reg(input int a, input logic [NB-1:0] we, input logic [DATA_W-1:0] d);
    bus.waddr = AW'(a);
    bus.wen   = we;
    bus.wdata = d;
    step();
    bus.wen = '0;
  endtask

  task automatic read_port(input int p, input int a, input logic [NB-1:0] re);
    bus.raddr[p*AW +: AW] = AW'(a);
    bus.ren[p*NB +: NB]   = re;
  endtask

  task automatic do_reset();
    resetn = 1'b0;
    #1;
    model_reset();
    check_eq("rst_busy", bus.clr_busy, 1'b0);
    bus.ren = '1;
    for (int a = 0; a < NREG; a++) begin
      bus.test_addr = AW'(a);
      for (int p = 0; p < NRD; p++) bus.raddr[p*AW +: AW] = AW'(a);
      #1;
      check_eq("rst_test_data", bus.test_data, '0);
      for (int p = 0; p < NRD; p++) begin
        check_eq("rst_rdata", bus.rdata[p*DATA_W +: DATA_W], '0);
        check_eq("rst_rpend", bus.rpend[p], 1'b0);
      end
    end
    @(posedge clk);
    #1;
    resetn = 1'b1;
    idle_inputs();
  endtask

  int busy_cnt;
  logic [DATA_W-1:0] old3;

  initial begin
    idle_inputs();
    model_reset();
    resetn = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    do_reset();

    // byte-enable merge on reg 5
    write_reg(5, 4'b0011, 32'hAABBCCDD);
    write_reg(5, 4'b1100, 32'h11223344);
    read_port(0, 5, 4'hF);
    read_port(1, 5, 4'b0011);
    #1;
    check_eq("r5_full", bus.rdata[0 +: DATA_W], 32'h1122CCDD);
    check_eq("r5_low", bus.rdata[DATA_W +: DATA_W], 32'h0000CCDD);
    step();

    // register 0 ignores writes and marks
    bus.mark_en = 1'b1;
    bus.mark_addr = '0;
    write_reg(0, 4'hF, 32'hFFFFFFFF);
    bus.mark_en = 1'b0;
    read_port(0, 0, 4'hF);
    bus.test_addr = '0;
    #1;
    check_eq("r0_rdata", bus.rdata[0 +: DATA_W], '0);
    check_eq("r0_rpend", bus.rpend[0], 1'b0);
    check_eq("r0_test", bus.test_data, '0);
    step();

    // pending bit life cycle on reg 7
    bus.mark_en = 1'b1;
    bus.mark_addr = AW'(7);
    step();
    bus.mark_en = 1'b0;
    read_port(0, 7, 4'hF);
    #1;
    check_eq("r7_marked", bus.rpend[0], 1'b1);
    write_reg(7, 4'hF, 32'h12345678);
    #1;
    check_eq("r7_wr_pend", bus.rpend[0], 1'b0);
    check_eq("r7_wr_data", bus.rdata[0 +: DATA_W], 32'h12345678);
    bus.mark_en = 1'b1;
    bus.mark_addr = AW'(7);
    write_reg(7, 4'hF, 32'h9ABCDEF0);
    bus.mark_en = 1'b0;
    #1;
    check_eq("r7_markwr_pend", bus.rpend[0], 1'b1);
    check_eq("r7_markwr_data", bus.rdata[0 +: DATA_W], 32'h9ABCDEF0);
    step();

    // same-cycle read of a register being written
    write_reg(3, 4'hF, 32'h01020304);
    old3 = 32'h01020304;
    read_port(1, 3, 4'hF);
    bus.waddr = AW'(3);
    bus.wen   = 4'hF;
    bus.wdata = 32'hCAFEF00D;
    #1;
`ifdef RF_BYPASS_EN
    check_eq("bypass_rd", bus.rdata[DATA_W +: DATA_W], 32'hCAFEF00D);
`else
    check_eq("nobypass_rd", bus.rdata[DATA_W +: DATA_W], old3);
`endif
    step();
    bus.wen = '0;

    // fill, sweep, count busy cycles; writes during the sweep are dropped
    for (int a = 1; a < NREG; a++) write_reg(a, 4'hF, $urandom());
    bus.clr_req = 1'b1;
    step();
    bus.clr_req = 1'b0;
    busy_cnt = 0;
    for (int n = 0; n < 2 * NREG; n++) begin
      if (!bus.clr_busy) break;
      busy_cnt++;
      bus.test_addr = AW'(busy_cnt);
      bus.waddr = AW'($urandom_range(1, NREG - 1));
      bus.wen   = 4'hF;
      bus.wdata = $urandom();
      step();
    end
    bus.wen = '0;
    check_eq("sweep_len", busy_cnt, NREG - 1);
    for (int a = 0; a < NREG; a++) begin
      bus.test_addr = AW'(a);
      #1;
      check_eq("swept_zero", bus.test_data, '0);
    end
    step();

    // reset in the middle of a sweep
    for (int a = 1; a < NREG; a++) write_reg(a, 4'hF, $urandom());
    bus.clr_req = 1'b1;
    step();
    bus.clr_req = 1'b0;
    repeat (6) step();
    do_reset();

    // random traffic
    for (int n = 0; n < 600; n++) begin
      bus.wen       = NB'($urandom());
      bus.waddr     = AW'($urandom_range(0, NREG - 1));
      bus.wdata     = $urandom();
      bus.mark_en   = ($urandom_range(0, 3) == 0);
      bus.mark_addr = ($urandom_range(0, 3) == 0) ? bus.waddr : AW'($urandom_range(0, NREG - 1));
      bus.clr_req   = ($urandom_range(0, 59) == 0);
      bus.ren       = (NRD*NB)'($urandom());
      for (int p = 0; p < NRD; p++)
        bus.raddr[p*AW +: AW] = ($urandom_range(0, 1) == 0) ? bus.waddr : AW'($urandom_range(0, NREG - 1));
      bus.test_addr = AW'($urandom_range(0, NREG - 1));
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/regfile_mp.md
Name: regfile_mp

Overview:
- Parametrised multi-port register file for the pipelined CPU core.
- Generalises the current RF in four ways:
  - configurable width, depth and read-port count;
  - byte-granular write and read enables;
  - per-register pending (scoreboard) bits for hazard detection;
  - a sequenced clear sweep.
- Sits between decode (read, mark) and writeback (write).
- Debug port feeds the test harness.

Parameters:
- DATA_W, 32: data width; must be a multiple of 8. NB = DATA_W/8.
- NREG, 32: number of registers, ≥4, power of two. AW = $clog2(NREG).
- NRD, 2: number of read ports, ≥1.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- resetn  in  1  asynchronous, active-low reset.
- wen  in  NB  per-byte write enable.
- waddr  in  AW  write address.
- wdata  in  DATA_W  write data.
- ren  in  NRD*NB  per-byte read enables; port i uses [i*NB +: NB].
- raddr  in  NRD*AW  read addresses; port i uses [i*AW +: AW].
- rdata  out  NRD*DATA_W  read data; port i uses [i*DATA_W +: DATA_W].
- rpend  out  NRD  pending bit of the register addressed by each port.
- mark_en  in  1  set pending bit of mark_addr.
- mark_addr  in  AW  register to mark pending.
- clr_req  in  1  start clear sweep (single-cycle pulse or level).
- clr_busy  out  1  sweep in progress.
- test_addr  in  AW  debug read address.
- test_data  out  DATA_W  debug read data.

Behaviour:
- Reset (resetn=0, asynchronous):
  - all registers and pending bits = 0;
  - FSM = IDLE, sweep index = 1, clr_busy = 0;
  - all combinational outputs are 0 as a consequence.
- Register 0 is hardwired:
  - reads as 0 and reports pending 0;
  - writes and marks to address 0 are dropped.
- Write (FSM IDLE):
  - at the edge, each byte k of rf[waddr] with wen[k]=1 takes wdata byte k; other bytes hold;
  - any |wen clears pending[waddr].
- Mark (FSM IDLE): mark_en sets pending[mark_addr].
  - Mark and write to the same address in the same cycle: pending ends at 1 (the new producer wins); data is still written.
- Read: combinational.
  - Byte k of port i = rf[raddr_i] byte k if ren bit is 1, else 0.
  - rpend[i] = pending[raddr_i].
  - Ports are independent; any ports may share an address.
- Debug: test_data = rf[test_addr] combinationally; ignores ren; address 0 gives 0.
- Clear FSM states: IDLE and SWEEP.
  - IDLE→SWEEP on clr_req=1. A write or mark in that same cycle is performed first.
  - In SWEEP, each cycle zeroes rf[idx] and pending[idx], then idx increments.
  - At idx=NREG-1, returns to IDLE and idx reloads to 1.
  - The sweep lasts exactly NREG-1 cycles.
  - clr_busy is 1 exactly while in SWEEP (registered).
- During SWEEP:
  - writes, marks and clr_req are dropped;
  - reads return live, partially cleared contents.
- resetn asserted mid-sweep → immediate IDLE with everything zeroed.

Optional Feature:
- Macro: RF_BYPASS_EN.
- Defined — same-cycle forwarding for read ports:
  - applies when FSM is IDLE, raddr_i==waddr≠0 and ren allows the byte;
  - bytes with wen[k]=1 come from wdata; other bytes come from the array;
  - rpend[i] is forced to 0 when |wen and the address is not also marked that cycle.
  - test_data is never bypassed.
- Undefined: reads see the new value only after the edge; rpend is not forced.

Test Plan:
- Reset, then read all addresses on every port with ren all-ones → rdata=0, rpend=0, clr_busy=0.
- Write reg 5 with wen=4'b0011, wdata=0xAABBCCDD, then wen=4'b1100, wdata=0x11223344 → next cycle reads 0x1122CCDD; ren=4'b0011 reads 0x0000CCDD.
- Write reg 0 with wen=4'hF, wdata=0xFFFFFFFF; mark reg 0 → rdata=0, rpend=0, test_data=0.
- Mark reg 7 → rpend=1 next cycle.
  - Then write reg 7 (0x12345678) → rpend=0 and data correct.
  - Then mark and write reg 7 together → rpend=1.
- Fill all regs, pulse clr_req → clr_busy high exactly NREG-1 cycles; regs zeroed in index order.
  - A write mid-sweep is dropped.
  - resetn pulsed mid-sweep → clr_busy=0 immediately, all zero.
- With RF_BYPASS_EN: write reg 3 = 0xCAFEF00D while port 1 reads reg 3 → same-cycle rdata=0xCAFEF00D; without the macro, the old value is read.
